// File: rtl/tama_host_seq.sv
// TAMA5 cart-bus initiator: expands one RAM/RTC request into the $A000/$A001
// cycle sequence (unlock, ready-poll, nibble writes, settle, optional readback).
module tama_host_seq #(
    parameter int unsigned POLL_MAX  = 8,
    parameter int unsigned SETTLE_CE = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_cpu,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_addr,
    input  logic [7:0]  req_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic [14:0] cart_addr,
    output logic        nCS,
    output logic        cart_wr,
    output logic        cart_rd,
    output logic [7:0]  cart_do,
    input  logic [7:0]  cart_di
);

    typedef enum logic [3:0] {
        S_IDLE, S_UNLOCK, S_POLL, S_DL, S_DH, S_CTRL, S_ADDR,
        S_SETTLE, S_RDL, S_RDH, S_RESP
    } state_t;

    localparam logic [3:0] POLL_LAST   = 4'(POLL_MAX - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CE - 1);

    state_t     state;
    logic [1:0] op;
    logic [4:0] addr;
    logic [7:0] data;
    logic       half;       // 0: index write to $A001, 1: data access at $A000
    logic       busy;       // a bus cycle is being driven
    logic [3:0] poll_cnt;
    logic [7:0] settle_cnt;

    logic       ram_read;
    logic [1:0] rtc_sel;
    logic       bus_rd;
    logic       bus_idx;
    logic [3:0] bus_nib;
    logic       unused_hi;

    assign ram_read  = (op == 2'b01);
    assign rtc_sel   = (op == 2'b10) ? 2'b01 : 2'b00;
    assign unused_hi = ^cart_di[7:4];

    always_comb begin
        bus_rd  = 1'b0;
        bus_idx = 1'b1;
        bus_nib = '0;
        case (state)
            S_UNLOCK: bus_nib = 4'hA;
            S_POLL: begin
                bus_rd  = 1'b1;
                bus_idx = 1'b0;
            end
            S_DL:   bus_nib = half ? data[3:0] : 4'h4;
            S_DH:   bus_nib = half ? data[7:4] : 4'h5;
            S_CTRL: bus_nib = half ? {rtc_sel, ram_read, addr[4]} : 4'h6;
            S_ADDR: bus_nib = half ? addr[3:0] : 4'h7;
            S_RDL:  bus_nib = half ? 4'h0 : 4'hC;
            S_RDH:  bus_nib = half ? 4'h0 : 4'hD;
            default: ;
        endcase
        if (half && state != S_UNLOCK && state != S_POLL) begin
            bus_idx = 1'b0;
            bus_rd  = (state == S_RDL) || (state == S_RDH);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            cart_addr  <= '0;
            nCS        <= 1'b1;
            cart_wr    <= 1'b0;
            cart_rd    <= 1'b0;
            cart_do    <= '0;
            op         <= '0;
            addr       <= '0;
            data       <= '0;
            half       <= 1'b0;
            busy       <= 1'b0;
            poll_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        op        <= req_op;
                        addr      <= req_addr;
                        data      <= req_data;
                        req_ready <= 1'b0;
                        rsp_data  <= '0;
                        rsp_err   <= (req_op == 2'b11);
                        poll_cnt  <= '0;
                        half      <= 1'b0;
                        busy      <= 1'b0;
                        state     <= (req_op == 2'b11) ? S_RESP : S_UNLOCK;
                    end
                end
                S_SETTLE: begin
                    if (ce_cpu) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= ram_read ? S_RDL : S_RESP;
                        end else begin
                            settle_cnt <= settle_cnt + 8'd1;
                        end
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b1;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    if (!busy) begin
                        nCS       <= 1'b0;
                        cart_addr <= bus_idx ? 15'h2001 : 15'h2000;
                        cart_wr   <= !bus_rd;
                        cart_rd   <= bus_rd;
                        cart_do   <= bus_rd ? 8'h00 : {4'h0, bus_nib};
                        busy      <= 1'b1;
                    end else if (ce_cpu) begin
                        // The qualifying edge completes the cycle; the released
                        // clock that follows is the idle gap before the next launch.
                        nCS     <= 1'b1;
                        cart_wr <= 1'b0;
                        cart_rd <= 1'b0;
                        busy    <= 1'b0;
                        case (state)
                            S_UNLOCK: state <= S_POLL;
                            S_POLL: begin
                                if (cart_di[3:0] == 4'h1) begin
                                    state <= S_DL;
                                end else begin
                                    poll_cnt <= poll_cnt + 4'd1;
                                    if (poll_cnt == POLL_LAST) begin
                                        rsp_err <= 1'b1;
                                        state   <= S_RESP;
                                    end
                                end
                            end
                            default: begin
                                if (!half) begin
                                    half <= 1'b1;
                                end else begin
                                    half <= 1'b0;
                                    case (state)
                                        S_DL:   state <= S_DH;
                                        S_DH:   state <= S_CTRL;
                                        S_CTRL: state <= S_ADDR;
                                        S_ADDR: begin
                                            settle_cnt <= '0;
                                            state      <= S_SETTLE;
                                        end
                                        S_RDL: begin
                                            rsp_data[3:0] <= cart_di[3:0];
                                            state         <= S_RDH;
                                        end
                                        S_RDH: begin
                                            rsp_data[7:4] <= cart_di[3:0];
                                            state         <= S_RESP;
                                        end
                                        default: state <= S_IDLE;
                                    endcase
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/tama_host_seq.md
Name: tama_host_seq

Overview:
- Initiator-side sequencer for the TAMA5 cartridge register protocol.
- Takes one request at a time (RAM write, RAM read, or RTC register write). Expands it into the CPU-visible cart-bus cycle sequence at $A000/$A001: unlock, ready-poll, data nibbles, control, address, and readback.
- Sits on the cart bus in place of the CPU. Used by the OSD/save-state path and the mapper bench to access TAMA5 RAM/RTC while the emulated CPU is held.

Parameters:
- POLL_MAX, 8, ready-poll read attempts before aborting with rsp_err.
- SETTLE_CE, 2, ce_cpu strobes waited after the address write before RAM readback or response.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce_cpu  in  1  CPU clock enable; every bus cycle is qualified by it
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
- req_op  in  2  00 RAM write, 01 RAM read, 10 RTC write (rtc_sel=1), 11 reserved
- req_addr  in  5  register/RAM address
- req_data  in  8  write data
- rsp_valid  out  1  one-clk_sys pulse at completion
- rsp_data  out  8  read data (RAM read); 8'h00 otherwise
- rsp_err  out  1  qualifies rsp_valid; poll timeout or reserved op
- cart_addr  out  15  15'h2000 (data reg) or 15'h2001 (index reg)
- nCS  out  1  low during any bus cycle
- cart_wr  out  1  write strobe
- cart_rd  out  1  read strobe
- cart_do  out  8  write data, upper nibble 0
- cart_di  in  8  read data from mapper; only low nibble is used

Behaviour:
- Reset values: req_ready=0 during reset, then 1 in IDLE. rsp_valid=0, rsp_data=0, rsp_err=0, cart_addr=0, nCS=1, cart_wr=0, cart_rd=0, cart_do=0. FSM state is IDLE.
- Reset mid-sequence: the bus is released immediately (asynchronous), no response is generated, and the latched request is discarded.
- Bus cycle:
  - The FSM drives cart_addr, cart_do and the strobe with nCS=0, and holds them until the first clk_sys edge with ce_cpu=1.
  - Read data is sampled from cart_di[3:0] on that edge.
  - Strobe and nCS drop on the next clk_sys. One idle clk_sys follows before the next cycle.
  - Exactly one ce_cpu-qualified strobe occurs per bus cycle.
- Acceptance: in IDLE, req_valid latches op/addr/data and req_ready drops. op=11 produces rsp_valid with rsp_err=1 on the next clock, with no bus activity.
- State sequence (W = write, R = read, @1 = $A001, @0 = $A000):
  - UNLOCK: W@1=0xA.
  - POLL: R@0. If nibble==1, go to DL. Otherwise increment the poll counter and retry. After POLL_MAX failed reads, go to RESP with rsp_err=1.
  - DL: W@1=0x4, then W@0=req_data[3:0].
  - DH: W@1=0x5, then W@0=req_data[7:4].
  - CTRL: W@1=0x6, then W@0={rtc_sel[1:0], ram_read, addr[4]}.
    - RAM write: rtc_sel=00, ram_read=0.
    - RAM read: rtc_sel=00, ram_read=1.
    - RTC write: rtc_sel=01, ram_read=0.
  - ADDR: W@1=0x7, then W@0=addr[3:0].
  - SETTLE: count SETTLE_CE ce_cpu strobes with no bus activity.
  - RAM read only:
    - RDL: W@1=0xC, then R@0; the result becomes rsp_data[3:0].
    - RDH: W@1=0xD, then R@0; the result becomes rsp_data[7:4].
  - RESP: rsp_valid pulse for 1 clk, then IDLE.
- Bus-cycle counts: RAM/RTC write = 10 cycles (with a single poll); RAM read = 14 cycles.
- No clk_sys cycle has both cart_wr and cart_rd high.
- cart_do[7:4] is always 0.
- The poll counter is 4 bits and clears on accept.
- req_valid held during a busy sequence is ignored until IDLE. Back-to-back requests are allowed: a request can be accepted on the cycle after RESP.
- ce_cpu stuck low: the FSM stalls with the strobe held. This is not a timeout.

Test Plan:
- ce_cpu every clk, RAM write addr=0x13, data=0xA5 with mapper responding -> bus writes in order @1:A, R@0 (1), @1:4, @0:5, @1:5, @0:A, @1:6, @0:1, @1:7, @0:3. Then rsp_valid with rsp_err=0, and mapper RAM[0x13]=0xA5.
- RAM read addr=0x13 after the previous test -> 14 bus cycles, ending in index C/D reads. rsp_data=0xA5, rsp_err=0.
- RTC write addr=0x05, data=0x21 -> control write @0:4 (rtc_sel=01), address write @0:5. The mapper RTC hours register reads 0x21.
- Mapper poll returns 0x0 forever -> exactly POLL_MAX=8 poll reads, then rsp_valid with rsp_err=1, and no write to index 4.
- ce_cpu once every 4 clks -> each strobe spans ≤4 clks and exactly one ce_cpu. Same result as the first scenario.
- reset_n low during the DH cycle -> nCS=1 and strobes=0 asynchronously, no rsp_valid. After release, req_ready=1 and the next request completes normally.
